// File: rtl/console_host_com_pkg.sv
`default_nettype none
// ============================================================================
// Module      : console_host_com_pkg
// Description : Packet type codes and com_state values shared by both console
//               ends, the host handler's one-hot state codes and small
//               classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package console_host_com_pkg;

  typedef logic [3:0] btype_t;
  typedef logic [1:0] com_state_t;

  // Packet types carried on the com link
  localparam btype_t BTYPE_INIT = 4'h0;
  localparam btype_t BTYPE_CONF = 4'h1;
  localparam btype_t BTYPE_READ = 4'h2;
  localparam btype_t BTYPE_STOP = 4'h3;
  localparam btype_t BTYPE_RXD0 = 4'h4;
  localparam btype_t BTYPE_RXD1 = 4'h5;

  // Device com_state values mirrored on the host side
  localparam com_state_t COM_STATE_IDLE = 2'b00;
  localparam com_state_t COM_STATE_CONF = 2'b01;
  localparam com_state_t COM_STATE_READ = 2'b10;

  // One-hot state codes of the host command/receive FSM
  localparam int ST_W = 10;
  localparam logic [ST_W-1:0] ST_MAIN_IDLE = 10'b00_0000_0001;
  localparam logic [ST_W-1:0] ST_MAIN_WAIT = 10'b00_0000_0010;
  localparam logic [ST_W-1:0] ST_SEND_IDLE = 10'b00_0000_0100;
  localparam logic [ST_W-1:0] ST_SEND_WAIT = 10'b00_0000_1000;
  localparam logic [ST_W-1:0] ST_SEND_WORK = 10'b00_0001_0000;
  localparam logic [ST_W-1:0] ST_CMD_DONE  = 10'b00_0010_0000;
  localparam logic [ST_W-1:0] ST_READ_IDLE = 10'b00_0100_0000;
  localparam logic [ST_W-1:0] ST_READ_WORK = 10'b00_1000_0000;
  localparam logic [ST_W-1:0] ST_READ_WAIT = 10'b01_0000_0000;
  localparam logic [ST_W-1:0] ST_READ_DONE = 10'b10_0000_0000;

  // True for the four command types the host may send
  function automatic logic is_cmd_btype(input btype_t b);
    return (b <= BTYPE_STOP);
  endfunction

  // True for the two data packet types the device may return
  function automatic logic is_rxd_btype(input btype_t b);
    return (b == BTYPE_RXD0) || (b == BTYPE_RXD1);
  endfunction

  // Device mode entered once a command has been accepted by the link
  function automatic com_state_t cmd_to_com_state(input btype_t b);
    com_state_t s;
    case (b)
      BTYPE_CONF: s = COM_STATE_CONF;
      BTYPE_READ: s = COM_STATE_READ;
      default:    s = COM_STATE_IDLE;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/console_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : console_wait_timer
// Description : Saturating wait-cycle counter with clear/enable. expired is
//               raised on the TIMEOUT-th enabled cycle after a clear.
// Revision    : 1.0 - initial release
// ============================================================================
module console_wait_timer #(
  parameter int NUM_W   = 8,
  parameter int TIMEOUT = 'h80
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [NUM_W:0]   C_LIMIT = TIMEOUT[NUM_W:0];
  localparam logic [NUM_W:0]   C_ONE   = {{NUM_W{1'b0}}, 1'b1};
  localparam logic [NUM_W-1:0] C_MAX   = {NUM_W{1'b1}};

  logic [NUM_W-1:0] r_count;
  logic [NUM_W:0]   w_count_inc;

  // One extra bit so the compare cannot overflow at the top of the range
  assign w_count_inc = {1'b0, r_count} + C_ONE;
  assign expired     = en && (w_count_inc >= C_LIMIT);

  // Count enabled cycles, clear otherwise, hold at the maximum instead of wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && (r_count != C_MAX)) begin
      r_count <= w_count_inc[NUM_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/console_host_com.sv
`default_nettype none
// ============================================================================
// Module      : console_host_com
// Description : Host-side console command handler. Sends INIT/CONF/READ/STOP
//               packets for the upper layer, delivers RXD0/RXD1 packets to the
//               data sink and mirrors the device com_state.
// Revision    : 1.0 - initial release
// ============================================================================
module console_host_com
  import console_host_com_pkg::*;
#(
  parameter int TIMEOUT = 'h80,
  parameter int NUM_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fs_cmd,
  output logic       fd_cmd,
  input  logic [3:0] cmd_btype,
  output logic       fs_com_send,
  input  logic       fd_com_send,
  output logic [3:0] tx_btype,
  input  logic       fs_com_read,
  output logic       fd_com_read,
  input  logic [3:0] rx_btype,
  output logic       fs_read,
  input  logic       fd_read,
  output logic       rxd_sel,
  output logic [1:0] dev_state,
  output logic       err_timeout,
  output logic       err_btype
);

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_state_next;
  logic            w_wait_en;
  logic            w_expired;
  btype_t          r_tx_btype;
  com_state_t      r_dev_state;
  logic            r_rxd_sel;
  logic            r_err_timeout;
  logic            r_err_btype;

  // The timer runs only while waiting on the link or the sink
  assign w_wait_en = (r_state == ST_SEND_WAIT) || (r_state == ST_READ_WAIT);

  console_wait_timer #(
    .NUM_W   (NUM_W),
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!w_wait_en),
    .en      (w_wait_en),
    .expired (w_expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_MAIN_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; receive wins over command, handshake ack wins over timeout
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_MAIN_IDLE: w_state_next = ST_MAIN_WAIT;
      ST_MAIN_WAIT: begin
        if (fs_com_read) begin
          w_state_next = ST_READ_IDLE;
        end else if (fs_cmd) begin
          w_state_next = ST_SEND_IDLE;
        end
      end
      ST_SEND_IDLE: w_state_next = is_cmd_btype(cmd_btype) ? ST_SEND_WAIT : ST_CMD_DONE;
      ST_SEND_WAIT: begin
        if (fd_com_send) begin
          w_state_next = ST_SEND_WORK;
        end else if (w_expired) begin
          w_state_next = ST_CMD_DONE;
        end
      end
      ST_SEND_WORK: w_state_next = ST_CMD_DONE;
      ST_CMD_DONE:  if (!fs_cmd) w_state_next = ST_MAIN_WAIT;
      ST_READ_IDLE: w_state_next = ST_READ_WORK;
      ST_READ_WORK: w_state_next = is_rxd_btype(rx_btype) ? ST_READ_WAIT : ST_READ_DONE;
      ST_READ_WAIT: if (fd_read || w_expired) w_state_next = ST_READ_DONE;
      ST_READ_DONE: if (!fs_com_read) w_state_next = ST_MAIN_WAIT;
      default:      w_state_next = ST_MAIN_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state; illegal encodings decode to 0
  always_comb begin
    fs_com_send = 1'b0;
    fd_cmd      = 1'b0;
    fs_read     = 1'b0;
    fd_com_read = 1'b0;
    case (r_state)
      ST_SEND_WAIT: fs_com_send = 1'b1;
      ST_CMD_DONE:  fd_cmd      = 1'b1;
      ST_READ_WAIT: fs_read     = 1'b1;
      ST_READ_DONE: fd_com_read = 1'b1;
      default: ;
    endcase
  end

  // Packet type latch, device mode mirror, RXD selector and one-cycle error pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_btype    <= BTYPE_INIT;
      r_dev_state   <= COM_STATE_IDLE;
      r_rxd_sel     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_btype   <= 1'b0;
    end else begin
      r_err_timeout <= 1'b0;
      r_err_btype   <= 1'b0;
      case (r_state)
        ST_SEND_IDLE: begin
          r_tx_btype <= cmd_btype;
          if (!is_cmd_btype(cmd_btype)) r_err_btype <= 1'b1;
        end
        ST_SEND_WAIT: if (!fd_com_send && w_expired) r_err_timeout <= 1'b1;
        ST_SEND_WORK: r_dev_state <= cmd_to_com_state(r_tx_btype);
        ST_READ_WORK: begin
          if (is_rxd_btype(rx_btype)) begin
            r_rxd_sel <= rx_btype[0];
          end else begin
            r_err_btype <= 1'b1;
          end
        end
        ST_READ_WAIT: if (!fd_read && w_expired) r_err_timeout <= 1'b1;
        default: ;
      endcase
    end
  end

  assign tx_btype    = r_tx_btype;
  assign dev_state   = r_dev_state;
  assign rxd_sel     = r_rxd_sel;
  assign err_timeout = r_err_timeout;
  assign err_btype   = r_err_btype;

endmodule
`default_nettype wire

// File: tb/tb_console_host_com.sv
`default_nettype none
// ============================================================================
// Module      : tb_console_host_com
// Description : Self-checking bench for console_host_com. Transactions are
//               scored against a transaction-level model of command/receive
//               outcomes, wait lengths and the mirrored device mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_console_host_com;

  localparam int TMO = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic       fs_cmd, fd_cmd;
  logic [3:0] cmd_btype;
  logic       fs_com_send, fd_com_send;
  logic [3:0] tx_btype;
  logic       fs_com_read, fd_com_read;
  logic [3:0] rx_btype;
  logic       fs_read, fd_read;
  logic       rxd_sel;
  logic [1:0] dev_state;
  logic       err_timeout, err_btype;

  int vectors = 0;
  int miscompares = 0;

  // Model state: device mode and last RXD selector
  logic [1:0] m_dev = 2'b00;
  logic       m_rxd = 1'b0;

  console_host_com dut (
    .clk         (clk),
    .rst         (rst),
    .fs_cmd      (fs_cmd),
    .fd_cmd      (fd_cmd),
    .cmd_btype   (cmd_btype),
    .fs_com_send (fs_com_send),
    .fd_com_send (fd_com_send),
    .tx_btype    (tx_btype),
    .fs_com_read (fs_com_read),
    .fd_com_read (fd_com_read),
    .rx_btype    (rx_btype),
    .fs_read     (fs_read),
    .fd_read     (fd_read),
    .rxd_sel     (rxd_sel),
    .dev_state   (dev_state),
    .err_timeout (err_timeout),
    .err_btype   (err_btype)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] mode_after(input logic [3:0] b);
    case (b)
      4'd1:    return 2'b01;
      4'd2:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Issue one command. d = sample of fs_com_send on which the link acks (0 = never).
  // exp_lat = expected negedges from raising fs_cmd to first fs_com_send (0 = skip).
  task automatic do_cmd(input logic [3:0] b, input int d, input int exp_lat,
                        input int hold, input bit drop_mid);
    int cyc, lat, sends, tmo, bty, fd_cyc, done_cyc, hold_bad, e_sends;
    bit legal, ok;
    cyc = 0; lat = 0; sends = 0; tmo = 0; bty = 0; fd_cyc = -1; done_cyc = -1; hold_bad = 0;
    legal = (b <= 4'd3);
    ok    = legal && (d != 0) && (d <= TMO);
    e_sends = !legal ? 0 : (ok ? d : TMO);
    fs_cmd = 1'b1; cmd_btype = b;
    while (done_cyc < 0 && cyc < 400) begin
      @(negedge clk); cyc++;
      fd_com_send = 1'b0;
      if (fs_com_send) begin
        if (sends == 0) begin
          lat = cyc;
          if (drop_mid) fs_cmd = 1'b0;
        end
        sends++;
        if (sends == d) begin fd_com_send = 1'b1; fd_cyc = cyc; end
      end
      if (err_timeout) tmo++;
      if (err_btype) bty++;
      if (fd_cmd) done_cyc = cyc;
    end
    fd_com_send = 1'b0;
    if (ok) m_dev = mode_after(b);
    vectors++;
    if (done_cyc < 0) begin miscompares++; $display("FAIL cmd_done: fd_cmd never seen, btype %0d", b); end
    vectors++;
    if (sends != e_sends) begin miscompares++; $display("FAIL cmd_send_len: got %0d cycles, want %0d (btype %0d d %0d)", sends, e_sends, b, d); end
    vectors++;
    if (tmo != ((legal && !ok) ? 1 : 0)) begin miscompares++; $display("FAIL cmd_err_timeout: got %0d pulses, want %0d", tmo, (legal && !ok) ? 1 : 0); end
    vectors++;
    if (bty != (legal ? 0 : 1)) begin miscompares++; $display("FAIL cmd_err_btype: got %0d pulses, want %0d", bty, legal ? 0 : 1); end
    vectors++;
    if (tx_btype !== b) begin miscompares++; $display("FAIL cmd_tx_btype: got %0d, want %0d", tx_btype, b); end
    vectors++;
    if (dev_state !== m_dev) begin miscompares++; $display("FAIL cmd_dev_state: got %b, want %b", dev_state, m_dev); end
    if (legal && exp_lat != 0) begin
      vectors++;
      if (lat != exp_lat) begin miscompares++; $display("FAIL cmd_latency: got %0d, want %0d", lat, exp_lat); end
    end
    if (ok) begin
      vectors++;
      if (done_cyc != fd_cyc + 2) begin miscompares++; $display("FAIL cmd_done_latency: got %0d, want %0d", done_cyc - fd_cyc, 2); end
    end
    repeat (hold) begin
      @(negedge clk);
      if (fd_cmd !== 1'b1 || err_timeout !== 1'b0 || err_btype !== 1'b0) hold_bad++;
    end
    if (hold > 0) begin
      vectors++;
      if (hold_bad != 0) begin miscompares++; $display("FAIL cmd_hold: %0d bad cycles, want 0", hold_bad); end
    end
    fs_cmd = 1'b0;
    @(negedge clk);
    vectors++;
    if (fd_cmd !== 1'b0) begin miscompares++; $display("FAIL cmd_release: fd_cmd got %b, want 0", fd_cmd); end
  endtask

  // Deliver one received packet. d = fs_read sample on which the sink acks (0 = never).
  task automatic do_read(input logic [3:0] r, input int d, input int hold);
    int cyc, reads, tmo, bty, sends, done_cyc, hold_bad, e_reads;
    bit legal, ok;
    cyc = 0; reads = 0; tmo = 0; bty = 0; sends = 0; done_cyc = -1; hold_bad = 0;
    legal = (r == 4'd4) || (r == 4'd5);
    ok    = legal && (d != 0) && (d <= TMO);
    e_reads = !legal ? 0 : (ok ? d : TMO);
    fs_com_read = 1'b1; rx_btype = r;
    while (done_cyc < 0 && cyc < 400) begin
      @(negedge clk); cyc++;
      fd_read = 1'b0;
      if (fs_read) begin
        reads++;
        if (reads == d) fd_read = 1'b1;
      end
      if (fs_com_send) sends++;
      if (err_timeout) tmo++;
      if (err_btype) bty++;
      if (fd_com_read) done_cyc = cyc;
    end
    fd_read = 1'b0;
    if (legal) m_rxd = r[0];
    vectors++;
    if (done_cyc < 0) begin miscompares++; $display("FAIL rd_done: fd_com_read never seen, rx_btype %0d", r); end
    vectors++;
    if (reads != e_reads) begin miscompares++; $display("FAIL rd_read_len: got %0d cycles, want %0d (rx_btype %0d d %0d)", reads, e_reads, r, d); end
    vectors++;
    if (tmo != ((legal && !ok) ? 1 : 0)) begin miscompares++; $display("FAIL rd_err_timeout: got %0d pulses, want %0d", tmo, (legal && !ok) ? 1 : 0); end
    vectors++;
    if (bty != (legal ? 0 : 1)) begin miscompares++; $display("FAIL rd_err_btype: got %0d pulses, want %0d", bty, legal ? 0 : 1); end
    vectors++;
    if (rxd_sel !== m_rxd) begin miscompares++; $display("FAIL rd_rxd_sel: got %b, want %b", rxd_sel, m_rxd); end
    vectors++;
    if (sends != 0 || dev_state !== m_dev) begin
      miscompares++; $display("FAIL rd_side_effects: sends %0d dev_state %b, want 0 and %b", sends, dev_state, m_dev);
    end
    repeat (hold) begin
      @(negedge clk);
      if (fd_com_read !== 1'b1 || err_timeout !== 1'b0 || err_btype !== 1'b0) hold_bad++;
    end
    if (hold > 0) begin
      vectors++;
      if (hold_bad != 0) begin miscompares++; $display("FAIL rd_hold: %0d bad cycles, want 0", hold_bad); end
    end
    fs_com_read = 1'b0;
    @(negedge clk);
    vectors++;
    if (fd_com_read !== 1'b0) begin miscompares++; $display("FAIL rd_release: fd_com_read got %b, want 0", fd_com_read); end
  endtask

  task automatic test_reset();
    logic [16:0] obs;
    rst = 1'b0; fs_cmd = 0; cmd_btype = 0; fd_com_send = 0;
    fs_com_read = 0; rx_btype = 0; fd_read = 0;
    repeat (3) @(negedge clk);
    obs = {fd_cmd, fs_com_send, fd_com_read, fs_read, tx_btype, rxd_sel, dev_state, err_timeout, err_btype, 4'h0};
    vectors++;
    if (obs !== 17'h0) begin miscompares++; $display("FAIL reset_outputs: got %h, want 0", obs); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_conf();
    do_cmd(4'd1, 4, 2, 2, 1'b0);
  endtask

  task automatic test_send_timeout();
    do_cmd(4'd2, 0, 2, 1, 1'b0);    // never acked: times out, mode unchanged
    do_cmd(4'd2, TMO, 2, 0, 1'b0);  // ack on the timeout cycle wins
    do_cmd(4'd3, TMO + 1, 2, 0, 1'b0);
    do_cmd(4'd1, TMO - 1, 2, 0, 1'b0);
  endtask

  task automatic test_rxd1();
    do_read(4'd5, 10, 2);
    do_read(4'd4, 0, 1);
    do_read(4'd5, TMO, 0);
  endtask

  task automatic test_illegal();
    do_cmd(4'd7, 3, 0, 1, 1'b0);
    do_read(4'd2, 3, 1);
  endtask

  task automatic test_drop_mid();
    do_cmd(4'd3, 3, 2, 0, 1'b1);
  endtask

  task automatic test_simultaneous();
    fs_cmd = 1'b1; cmd_btype = 4'd1;
    do_read(4'd4, 2, 0);
    do_cmd(4'd1, 2, 0, 1, 1'b0);
  endtask

  task automatic test_async_reset();
    int n;
    logic [16:0] obs;
    do_cmd(4'd2, 3, 2, 0, 1'b0);
    do_read(4'd5, 2, 0);
    fs_com_read = 1'b1; rx_btype = 4'd4;
    n = 0;
    while (!fs_read && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (!fs_read) begin miscompares++; $display("FAIL arst_setup: fs_read got 0, want 1"); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    obs = {fd_cmd, fs_com_send, fd_com_read, fs_read, tx_btype, rxd_sel, dev_state, err_timeout, err_btype, 4'h0};
    vectors++;
    if (obs !== 17'h0) begin miscompares++; $display("FAIL arst_outputs: got %h, want 0", obs); end
    fs_com_read = 1'b0;
    @(negedge clk);
    rst = 1'b1; m_dev = 2'b00; m_rxd = 1'b0;
    do_cmd(4'd0, 2, 3, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] b;
    int d, pick;
    for (int i = 0; i < 30; i++) begin
      pick = $urandom_range(0, 15);
      d = (pick == 0) ? 0 : (pick == 1) ? TMO : $urandom_range(1, 8);
      if ($urandom_range(0, 1) == 0) begin
        b = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
        do_cmd(b, d, 2, $urandom_range(0, 3), 1'b0);
      end else begin
        b = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(4, 5));
        do_read(b, d, $urandom_range(0, 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_conf();
    test_send_timeout();
    test_rxd1();
    test_illegal();
    test_drop_mid();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
